// File: rtl/ucore_sequencer.sv
// Microcoded control sequencer: fetches one micro-instruction per RUN cycle from an external store.
// Optional return stack (CALL/RET) enabled by defining UCORE_SEQUENCER_STACK_EN.
module ucore_sequencer #(
    parameter int unsigned          STATE_W    = 12,
    parameter int unsigned          COND_W     = 8,
    parameter int unsigned          OUT_W      = 16,
    parameter int unsigned          STACK_D    = 4,
    parameter logic [STATE_W-1:0]   START_ADDR = '0,
    localparam int unsigned         CSEL_W     = (COND_W > 1) ? $clog2(COND_W) : 1,
    localparam int unsigned         UW         = 3 + CSEL_W + STATE_W + OUT_W
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               abort,
    input  logic [COND_W-1:0]  cond,
    output logic [STATE_W-1:0] uaddr,
    input  logic [UW-1:0]      udata,
    output logic [OUT_W-1:0]   ctrl_out,
    output logic               busy,
    output logic               done,
    output logic               fault
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFault
    } state_e;

    typedef enum logic [2:0] {
        OpNext,
        OpJmp,
        OpBrt,
        OpWait,
        OpCall,
        OpRet,
        OpHalt,
        OpIll
    } op_e;

    state_e               state_q;
    logic [STATE_W-1:0]   upc_q;
    logic [OUT_W-1:0]     ctrl_q;
    logic                 done_q;

    // Instruction field decode
    op_e                  op;
    logic [CSEL_W-1:0]    csel;
    logic [STATE_W-1:0]   target;
    logic [OUT_W-1:0]     outv;
    logic [STATE_W-1:0]   upc_inc;
    logic                 cond_bit;
    logic [2**CSEL_W-1:0] cond_ext;

    assign op      = op_e'(udata[UW-1 -: 3]);
    assign csel    = udata[OUT_W+STATE_W +: CSEL_W];
    assign target  = udata[OUT_W +: STATE_W];
    assign outv    = udata[OUT_W-1:0];
    assign upc_inc = upc_q + STATE_W'(1);

    // Selectors past the last real condition read as false.
    always_comb begin
        cond_ext              = '0;
        cond_ext[COND_W-1:0]  = cond;
        cond_bit              = cond_ext[csel];
    end

`ifdef UCORE_SEQUENCER_STACK_EN
    localparam int unsigned SP_W  = $clog2(STACK_D + 1);
    localparam int unsigned IDX_W = (STACK_D > 1) ? $clog2(STACK_D) : 1;

    logic [STATE_W-1:0] stack_q [STACK_D];
    logic [SP_W-1:0]    sp_q;
    logic               stack_full;
    logic               stack_empty;
    logic               push_en;
    logic [IDX_W-1:0]   push_idx;
    logic [IDX_W-1:0]   pop_idx;

    assign stack_full  = (sp_q == SP_W'(STACK_D));
    assign stack_empty = (sp_q == '0);
    assign push_idx    = IDX_W'(sp_q);
    assign pop_idx     = IDX_W'(sp_q - SP_W'(1));
    assign push_en     = (state_q == StRun) && !abort && (op == OpCall) && !stack_full;

    // Entries need no reset: only the pointer decides what is live.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_q[push_idx] <= upc_inc;
        end
    end
`else
    logic unused_stack_d;
    assign unused_stack_d = ^STACK_D;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            upc_q   <= START_ADDR;
            ctrl_q  <= '0;
            done_q  <= 1'b0;
`ifdef UCORE_SEQUENCER_STACK_EN
            sp_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle, StFault: begin
                    if (abort) begin
                        state_q <= StIdle;
                    end else if (start) begin
                        state_q <= StRun;
                        upc_q   <= START_ADDR;
`ifdef UCORE_SEQUENCER_STACK_EN
                        sp_q    <= '0;
`endif
                    end
                end
                StRun: begin
                    if (abort) begin
                        state_q <= StIdle;
`ifdef UCORE_SEQUENCER_STACK_EN
                        sp_q    <= '0;
`endif
                    end else begin
                        ctrl_q <= outv;
                        unique case (op)
                            OpNext: upc_q <= upc_inc;
                            OpJmp:  upc_q <= target;
                            OpBrt:  upc_q <= cond_bit ? target : upc_inc;
                            OpWait: begin
                                if (cond_bit) begin
                                    upc_q <= upc_inc;
                                end
                            end
`ifdef UCORE_SEQUENCER_STACK_EN
                            OpCall: begin
                                if (stack_full) begin
                                    state_q <= StFault;
                                end else begin
                                    sp_q  <= sp_q + SP_W'(1);
                                    upc_q <= target;
                                end
                            end
                            OpRet: begin
                                if (stack_empty) begin
                                    state_q <= StFault;
                                end else begin
                                    sp_q  <= sp_q - SP_W'(1);
                                    upc_q <= stack_q[pop_idx];
                                end
                            end
`else
                            OpCall: state_q <= StFault;
                            OpRet:  state_q <= StFault;
`endif
                            OpHalt: begin
                                state_q <= StIdle;
                                done_q  <= 1'b1;
                            end
                            OpIll:  state_q <= StFault;
                            default: state_q <= StFault;
                        endcase
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign uaddr    = upc_q;
    assign ctrl_out = ctrl_q;
    assign busy     = (state_q == StRun);
    assign fault    = (state_q == StFault);
    assign done     = done_q;

endmodule

// File: tb/tb_ucore_sequencer.sv
// Directed bench for ucore_sequencer: a small micro-store array drives udata from uaddr.
// Stack tests follow UCORE_SEQUENCER_STACK_EN; the default build checks CALL as illegal.
module tb_ucore_sequencer;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned COND_W  = 6;
    localparam int unsigned OUT_W   = 16;
    localparam int unsigned STACK_D = 2;
    localparam int unsigned UW      = 3 + 3 + STATE_W + OUT_W;

    localparam logic [2:0] OP_NEXT = 3'd0;
    localparam logic [2:0] OP_JMP  = 3'd1;
    localparam logic [2:0] OP_BRT  = 3'd2;
    localparam logic [2:0] OP_WAIT = 3'd3;
    localparam logic [2:0] OP_CALL = 3'd4;
    localparam logic [2:0] OP_RET  = 3'd5;
    localparam logic [2:0] OP_HALT = 3'd6;
    localparam logic [2:0] OP_ILL  = 3'd7;

    logic               clk = 1'b0;
    logic               resetn;
    logic               start;
    logic               abort;
    logic [COND_W-1:0]  cond;
    logic [STATE_W-1:0] uaddr;
    logic [UW-1:0]      udata;
    logic [OUT_W-1:0]   ctrl_out;
    logic               busy;
    logic               done;
    logic               fault;

    logic [UW-1:0] rom [16];
    int n_asrt = 0;
    int n_fail = 0;

    assign udata = rom[uaddr];

    always #5 clk = ~clk;

    ucore_sequencer #(
        .STATE_W    (STATE_W),
        .COND_W     (COND_W),
        .OUT_W      (OUT_W),
        .STACK_D    (STACK_D),
        .START_ADDR (4'd0)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .abort    (abort),
        .cond     (cond),
        .uaddr    (uaddr),
        .udata    (udata),
        .ctrl_out (ctrl_out),
        .busy     (busy),
        .done     (done),
        .fault    (fault)
    );

    function automatic logic [UW-1:0] ins(input logic [2:0] op, input logic [2:0] csel,
                                          input logic [3:0] tgt, input logic [15:0] outv);
        return {op, csel, tgt, outv};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = ins(OP_HALT, 3'd0, 4'd0, 16'h0);
    endtask

    initial begin
        resetn = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        cond   = '0;
        clear_rom();
        #3;
        chk("rst_uaddr", 32'(uaddr), 32'd0);
        chk("rst_ctrl", 32'(ctrl_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        resetn = 1'b1;
        tick();

        // Basic program: NEXT, JMP 4, HALT
        rom[0] = ins(OP_NEXT, 3'd0, 4'd0, 16'd1);
        rom[1] = ins(OP_JMP, 3'd0, 4'd4, 16'd1);
        rom[4] = ins(OP_HALT, 3'd0, 4'd0, 16'd9);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("p1_busy", 32'(busy), 32'd1);
        chk("p1_ua0", 32'(uaddr), 32'd0);
        tick();
        chk("p1_ua1", 32'(uaddr), 32'd1);
        chk("p1_ctrl1", 32'(ctrl_out), 32'd1);
        chk("p1_done_early", 32'(done), 32'd0);
        tick();
        chk("p1_ua4", 32'(uaddr), 32'd4);
        tick();
        chk("p1_done", 32'(done), 32'd1);
        chk("p1_ctrl9", 32'(ctrl_out), 32'd9);
        chk("p1_busy_off", 32'(busy), 32'd0);
        chk("p1_ua_held", 32'(uaddr), 32'd4);
        tick();
        chk("p1_done_pulse", 32'(done), 32'd0);
        chk("p1_ctrl_idle", 32'(ctrl_out), 32'd9);

        // WAIT on cond[2]
        clear_rom();
        rom[0] = ins(OP_WAIT, 3'd2, 4'd0, 16'd3);
        rom[1] = ins(OP_HALT, 3'd0, 4'd0, 16'd5);
        cond  = 6'b111011;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("wait_hold", 32'(uaddr), 32'd0);
        end
        cond = 6'b000100;
        tick();
        chk("wait_adv", 32'(uaddr), 32'd1);
        tick();
        chk("wait_done", 32'(done), 32'd1);
        cond = '0;

        // BRT: csel beyond COND_W reads false, taken and not-taken cases
        clear_rom();
        rom[0] = ins(OP_BRT, 3'd7, 4'd8, 16'd2);
        rom[1] = ins(OP_BRT, 3'd5, 4'd8, 16'd2);
        rom[8] = ins(OP_BRT, 3'd0, 4'd12, 16'd2);
        rom[9] = ins(OP_HALT, 3'd0, 4'd0, 16'd2);
        cond  = 6'b111110;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("brt_csel_oob", 32'(uaddr), 32'd1);
        tick();
        chk("brt_taken", 32'(uaddr), 32'd8);
        tick();
        chk("brt_not_taken", 32'(uaddr), 32'd9);
        tick();
        chk("brt_done", 32'(done), 32'd1);
        cond = '0;

        // Abort during WAIT wins over a satisfied condition
        clear_rom();
        rom[0] = ins(OP_NEXT, 3'd0, 4'd0, 16'h7);
        rom[1] = ins(OP_WAIT, 3'd1, 4'd0, 16'h11);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("ab_in_wait", 32'(uaddr), 32'd1);
        abort = 1'b1;
        cond  = 6'b000010;
        tick();
        abort = 1'b0;
        cond  = '0;
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_done", 32'(done), 32'd0);
        chk("ab_ua", 32'(uaddr), 32'd1);
        chk("ab_ctrl", 32'(ctrl_out), 32'h11);
        tick();
        chk("ab_done_after", 32'(done), 32'd0);

        // Abort beats start in IDLE; start ignored while running
        clear_rom();
        rom[0] = ins(OP_NEXT, 3'd0, 4'd0, 16'h1);
        rom[1] = ins(OP_NEXT, 3'd0, 4'd0, 16'h2);
        rom[2] = ins(OP_HALT, 3'd0, 4'd0, 16'h3);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        chk("abst_idle", 32'(busy), 32'd0);
        tick();
        chk("st_run", 32'(busy), 32'd1);
        tick();
        start = 1'b0;
        chk("st_ignored", 32'(uaddr), 32'd1);
        tick();
        tick();
        chk("st_done", 32'(done), 32'd1);

        // Illegal opcode
        clear_rom();
        rom[0] = ins(OP_NEXT, 3'd0, 4'd0, 16'h21);
        rom[1] = ins(OP_ILL, 3'd0, 4'd0, 16'h33);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("ill_fault", 32'(fault), 32'd1);
        chk("ill_busy", 32'(busy), 32'd0);
        chk("ill_ua", 32'(uaddr), 32'd1);
        tick();
        chk("ill_fault_hold", 32'(fault), 32'd1);
        chk("ill_ua_hold", 32'(uaddr), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ill_abort_clr", 32'(fault), 32'd0);
        chk("ill_abort_busy", 32'(busy), 32'd0);

`ifdef UCORE_SEQUENCER_STACK_EN
        // Nested CALL/RET, then overflow on a third CALL
        clear_rom();
        rom[0] = ins(OP_CALL, 3'd0, 4'd4, 16'h1);
        rom[4] = ins(OP_CALL, 3'd0, 4'd8, 16'h2);
        rom[8] = ins(OP_RET, 3'd0, 4'd0, 16'h3);
        rom[5] = ins(OP_RET, 3'd0, 4'd0, 16'h4);
        rom[1] = ins(OP_HALT, 3'd0, 4'd0, 16'h5);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("call1", 32'(uaddr), 32'd4);
        tick();
        chk("call2", 32'(uaddr), 32'd8);
        tick();
        chk("ret1", 32'(uaddr), 32'd5);
        tick();
        chk("ret2", 32'(uaddr), 32'd1);
        tick();
        chk("call_done", 32'(done), 32'd1);
        rom[8] = ins(OP_CALL, 3'd0, 4'd12, 16'h3);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("ovf_fault", 32'(fault), 32'd1);
        chk("ovf_ua", 32'(uaddr), 32'd8);
        abort = 1'b1;
        tick();
        abort = 1'b0;
`else
        // CALL without the stack is an illegal op
        clear_rom();
        rom[0] = ins(OP_CALL, 3'd0, 4'd4, 16'h1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("call_ill_fault", 32'(fault), 32'd1);
        chk("call_ill_ua", 32'(uaddr), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
`endif

        // RET at entry faults; start recovers
        clear_rom();
        rom[0] = ins(OP_RET, 3'd0, 4'd0, 16'h6);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("ret_uf_fault", 32'(fault), 32'd1);
        chk("ret_uf_ua", 32'(uaddr), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ret_restart_fault", 32'(fault), 32'd0);
        chk("ret_restart_busy", 32'(busy), 32'd1);
        chk("ret_restart_ua", 32'(uaddr), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // upc wrap 15 -> 0, then reset mid-run
        clear_rom();
        rom[0]  = ins(OP_JMP, 3'd0, 4'd15, 16'hA);
        rom[15] = ins(OP_NEXT, 3'd0, 4'd0, 16'hF);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("wrap_at15", 32'(uaddr), 32'd15);
        tick();
        chk("wrap_to0", 32'(uaddr), 32'd0);
        chk("wrap_nofault", 32'(fault), 32'd0);
        chk("wrap_ctrl", 32'(ctrl_out), 32'hF);
        #2;
        resetn = 1'b0;
        #1;
        chk("mrst_ua", 32'(uaddr), 32'd0);
        chk("mrst_ctrl", 32'(ctrl_out), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_fault", 32'(fault), 32'd0);
        resetn = 1'b1;
        tick();
        chk("mrst_done_after", 32'(done), 32'd0);
        chk("mrst_busy_after", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/ucore_sequencer.md
UCORE_SEQUENCER -- requirements
Module: ucore_sequencer

Interface
REQ-001 The block SHALL have parameter STATE_W, default 12, micro-program counter width.
REQ-002 The block SHALL have parameter COND_W, default 8, number of condition inputs; CSEL_W = clog2(COND_W).
REQ-003 The block SHALL have parameter OUT_W, default 16, control-word output width.
REQ-004 The block SHALL have parameter STACK_D, default 4, return-stack depth.
REQ-005 The block SHALL have parameter START_ADDR, default 0, first micro-address executed after start.
REQ-006 The block SHALL have the following ports, as name  direction  width  meaning:
- clk  input  1  clock.
- resetn  input  1  reset, asynchronous, active-low.
- start  input  1  launch the program from START_ADDR.
- abort  input  1  synchronous abort back to IDLE.
- cond  input  COND_W  branch/wait condition vector.
- uaddr  output  STATE_W  micro-store address; equals upc.
- udata  input  3+CSEL_W+STATE_W+OUT_W  micro-instruction, combinational in uaddr, fields MSB..LSB {op[2:0], csel, target, outv}.
- ctrl_out  output  OUT_W  registered control word.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse on HALT.
- fault  output  1  high in FAULT.

Function
REQ-007 The block SHALL have three FSM states (IDLE, RUN, FAULT) and a register upc.
REQ-008 In IDLE or FAULT, start=1 SHALL load upc=START_ADDR, empty the stack and enter RUN next cycle; fault SHALL then clear.
REQ-009 Each RUN cycle SHALL execute exactly one instruction from udata and load ctrl_out<=outv.
REQ-010 op=0 NEXT SHALL set upc<=upc+1.
REQ-011 op=1 JMP SHALL set upc<=target.
REQ-012 op=2 BRT SHALL set upc<=target if cond[csel]=1, else upc+1.
REQ-013 op=3 WAIT SHALL hold upc while cond[csel]=0, and set upc+1 in the cycle it is 1.
REQ-014 op=4 CALL SHALL push upc+1 and set upc<=target.
REQ-015 op=5 RET SHALL pop the stack into upc.
REQ-016 op=6 HALT SHALL go to IDLE and pulse done for one cycle; upc SHALL be held.
REQ-017 op=7 SHALL be illegal and go to FAULT.
REQ-018 upc+1 SHALL wrap modulo 2^STATE_W without fault.
REQ-019 A csel value >= COND_W SHALL read as condition 0 (false).
REQ-020 CALL with the stack holding STACK_D entries (overflow), or RET with it empty (underflow), SHALL enter FAULT; upc and the stack SHALL be unchanged.
REQ-021 abort=1 in RUN SHALL go to IDLE next cycle without a done pulse and SHALL empty the stack; abort SHALL take priority over the current instruction.
REQ-022 start in RUN SHALL be ignored; abort and start together in IDLE/FAULT SHALL give priority to abort, staying in or returning to IDLE.
REQ-023 In FAULT, ctrl_out, upc and stack SHALL hold until start, abort or reset; abort SHALL go to IDLE and clear fault.
REQ-024 ctrl_out SHALL hold its value in IDLE.

Reset
REQ-025 resetn=0 SHALL asynchronously force IDLE, upc=START_ADDR, ctrl_out=0, stack empty, busy=0, done=0, fault=0.
REQ-026 Reset asserted mid-program SHALL discard all state; no done pulse SHALL be produced.

Configuration
REQ-027 With macro UCORE_SEQUENCER_STACK_EN defined, the return stack and CALL/RET SHALL be implemented per REQ-014, REQ-015 and REQ-020.
REQ-028 Without UCORE_SEQUENCER_STACK_EN, no stack storage SHALL exist and CALL/RET SHALL be illegal ops, entering FAULT as op=7 does.

Verification
REQ-029 Reset, then start with program {0:NEXT outv=1, 1:JMP 4, 4:HALT outv=9} -> uaddr sequence 0,1,4; ctrl_out 1 then 9; done pulses once at cycle 3; busy low after.
REQ-030 WAIT csel=2 with cond[2]=0 for 5 cycles, then 1 -> uaddr held 5 cycles, advances on cycle 6.
REQ-031 With STACK_D=2 and the macro on, nested CALL x2 then RET x2 -> returns to the correct addresses; a third nested CALL -> fault=1 and upc unchanged.
REQ-032 RET at program entry -> FAULT; then start -> RUN from START_ADDR with fault=0.
REQ-033 abort during WAIT -> IDLE next cycle, no done pulse; resetn low mid-run -> outputs at reset values immediately.
REQ-034 Macro off, CALL opcode -> fault=1; with STATE_W=4, NEXT at upc=15 -> upc=0.
